// File: rtl/program_loader.sv
// Host-side program loader: buffers a program image from a byte source, then
// walks the CPU control block through programming mode one byte per
// instruction cycle and releases it into normal execution at PC 0.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset; CPU held in reset, waiting for start
// FILL   | accepting host bytes into the buffer, CPU held in reset
// ARM    | CPU released, waiting for its first T0 (cpu_ready)
// LOAD   | programming=1, presenting buf[idx], counting RAM writes
// EXIT   | all bytes written, waiting for T0 to leave programming mode
// RUN    | CPU executing the loaded image; start begins a reload
module program_loader #(
  parameter int PROG_LEN = 16,
  parameter int ADDR_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] host_data,
  input  logic       host_valid,
  output logic       host_ready,
  output logic       cpu_resetn,
  output logic       programming,
  output logic [7:0] prog_data,
  input  logic       cpu_ready,
  input  logic       cpu_read,
  input  logic       cpu_done_load,
  output logic       busy,
  output logic       loaded,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARM,
    S_LOAD,
    S_EXIT,
    S_RUN
  } state_t;

  // Index of the final byte; PROG_LEN equals the buffer depth, so both the
  // fill count and the load index wrap back to 0 after it.
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              host_ready_q, host_ready_d;
  logic              cpu_resetn_q, cpu_resetn_d;
  logic              programming_q, programming_d;
  logic              loaded_q, loaded_d;
  logic              error_q, error_d;
  // Per-instruction-cycle protocol tracking while in LOAD.
  logic              read_seen_q, read_seen_d;
  logic              done_seen_q, done_seen_d;
  logic              ready_seen_q, ready_seen_d;

  // Image buffer; deliberately not reset.
  logic [7:0]        mem_q [0:PROG_LEN-1];
  logic              mem_we;

  // Next-state and output decisions for every FSM register.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    idx_d         = idx_q;
    host_ready_d  = host_ready_q;
    cpu_resetn_d  = cpu_resetn_q;
    programming_d = programming_q;
    loaded_d      = loaded_q;
    error_d       = error_q;
    read_seen_d   = read_seen_q;
    done_seen_d   = done_seen_q;
    ready_seen_d  = ready_seen_q;
    mem_we        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // host_ready is still 0 here, so a byte offered alongside start
        // is never taken.
        if (start) begin
          state_d      = S_FILL;
          count_d      = '0;
          host_ready_d = 1'b1;
          error_d      = 1'b0;
        end
      end

      S_FILL: begin
        if (host_valid && host_ready_q) begin
          mem_we  = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            host_ready_d = 1'b0;
            cpu_resetn_d = 1'b1;
            state_d      = S_ARM;
          end
        end
      end

      S_ARM: begin
        // Enter programming mode on the T0 edge so programming is stable
        // for the whole of T1..T5.
        if (cpu_ready) begin
          programming_d = 1'b1;
          idx_d         = '0;
          read_seen_d   = 1'b0;
          done_seen_d   = 1'b0;
          ready_seen_d  = 1'b0;
          state_d       = S_LOAD;
        end
      end

      S_LOAD: begin
        if (cpu_read) begin
          read_seen_d = 1'b1;
        end
        if (cpu_ready) begin
          // A new instruction cycle without a RAM write in the previous one.
          if (ready_seen_q && !done_seen_q) begin
            error_d = 1'b1;
          end
          ready_seen_d = 1'b1;
          done_seen_d  = 1'b0;
          read_seen_d  = 1'b0;
        end
        if (cpu_done_load) begin
          if (!read_seen_q) begin
            error_d = 1'b1;
          end
          // Advance regardless so idx keeps tracking the CPU's PC.
          idx_d       = idx_q + 1'b1;
          done_seen_d = 1'b1;
          if (idx_q == LAST) begin
            state_d = S_EXIT;
          end
        end
      end

      S_EXIT: begin
        if (cpu_ready) begin
          programming_d = 1'b0;
          loaded_d      = 1'b1;
          state_d       = S_RUN;
        end
      end

      S_RUN: begin
        if (start) begin
          cpu_resetn_d  = 1'b0;
          programming_d = 1'b0;
          loaded_d      = 1'b0;
          count_d       = '0;
          host_ready_d  = 1'b1;
          error_d       = 1'b0;
          state_d       = S_FILL;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      idx_q         <= '0;
      host_ready_q  <= 1'b0;
      cpu_resetn_q  <= 1'b0;
      programming_q <= 1'b0;
      loaded_q      <= 1'b0;
      error_q       <= 1'b0;
      read_seen_q   <= 1'b0;
      done_seen_q   <= 1'b0;
      ready_seen_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      host_ready_q  <= host_ready_d;
      cpu_resetn_q  <= cpu_resetn_d;
      programming_q <= programming_d;
      loaded_q      <= loaded_d;
      error_q       <= error_d;
      read_seen_q   <= read_seen_d;
      done_seen_q   <= done_seen_d;
      ready_seen_q  <= ready_seen_d;
    end
  end

  // Buffer write port, one byte per accepted host transfer.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[count_q] <= host_data;
    end
  end

  assign host_ready  = host_ready_q;
  assign cpu_resetn  = cpu_resetn_q;
  assign programming = programming_q;
  assign loaded      = loaded_q;
  assign error       = error_q;
  assign prog_data   = mem_q[idx_q];
  assign busy        = (state_q == S_FILL) || (state_q == S_ARM) ||
                       (state_q == S_LOAD) || (state_q == S_EXIT);

endmodule
